regfile_mp: RTL and testbench

- Parametrised multi-read-port integer register file for the RV32I core; successor to the fixed 32x32, two-read-port file.
- Adds configurable width, depth and read-port count, plus a per-register pending-write scoreboard for hazard detection.
- Adds a sequential clear-sweep engine that zeroes the file one entry per cycle on request.
- Sits between decode (reads and allocation) and writeback (writes).

---
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a pending-write scoreboard and clear-sweep FSM.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding on every read port.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWEn,
  input  logic [ADDR_W-1:0]        rsW,
  input  logic [DATA_W-1:0]        dataW,
  input  logic [NUM_RD*ADDR_W-1:0] rsR,
  output logic [NUM_RD*DATA_W-1:0] dataR,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              stateQ, stateD;
  logic [ADDR_W-1:0]   idxQ, idxD;
  logic [DATA_W-1:0]   regQ [DEPTH];
  logic [DATA_W-1:0]   regD [DEPTH];
  logic [DEPTH-1:0]    pendQ, pendD;

  logic sweeping;
  logic lastIdx;
  logic zeroW;
  logic zeroA;

  assign sweeping = (stateQ == StSweep);
  assign lastIdx  = (idxQ == ADDR_W'(DEPTH - 1));
  assign zeroW    = (ZERO_REG != 0) && (rsW == '0);
  assign zeroA    = (ZERO_REG != 0) && (alloc_addr == '0);
  assign clr_busy = sweeping;

  // Clear-sweep sequencer
  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    clr_done = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (clr_start) begin
          stateD = StSweep;
          idxD   = '0;
        end
      end
      StSweep: begin
        idxD = idxQ + 1'b1;
        if (lastIdx) begin
          clr_done = 1'b1;
          stateD   = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Priority: sweep clear, then writeback, then allocation (newest producer wins).
  always_comb begin
    regD  = regQ;
    pendD = pendQ;
    if (sweeping) begin
      regD[idxQ]  = '0;
      pendD[idxQ] = 1'b0;
    end
    if (RegWEn) begin
      if (!zeroW) begin
        regD[rsW] = dataW;
      end
      pendD[rsW] = 1'b0;
    end
    if (alloc_en && !zeroA) begin
      pendD[alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regD[0]  = '0;
      pendD[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      idxQ   <= '0;
      pendQ  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        regQ[i] <= '0;
      end
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      pendQ  <= pendD;
      regQ   <= regD;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic              isZero;

    assign addr   = rsR[k*ADDR_W +: ADDR_W];
    assign isZero = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    logic fwdAlloc;

    assign fwd      = RegWEn && (addr == rsW) && !isZero;
    // A same-cycle allocation makes the register pending again despite the forward.
    assign fwdAlloc = alloc_en && (alloc_addr == addr);

    assign dataR[k*DATA_W +: DATA_W] = isZero ? '0 : (fwd ? dataW : regQ[addr]);
    assign rd_pend[k]                = isZero ? 1'b0 : (fwd ? fwdAlloc : pendQ[addr]);
`else
    assign dataR[k*DATA_W +: DATA_W] = isZero ? '0 : regQ[addr];
    assign rd_pend[k]                = isZero ? 1'b0 : pendQ[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  localparam int KData = 0;
  localparam int KPend = 1;
  localparam int KBusy = 2;
  localparam int KDone = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             RegWEn;
  logic [AW-1:0]    rsW;
  logic [DW-1:0]    dataW;
  logic [NR*AW-1:0] rsR;
  logic [NR*DW-1:0] dataR;
  logic [NR-1:0]    rd_pend;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             clr_start;
  logic             clr_busy;
  logic             clr_done;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWEn    (RegWEn),
    .rsW       (rsW),
    .dataW     (dataW),
    .rsR       (rsR),
    .dataR     (dataR),
    .rd_pend   (rd_pend),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    e.cyc  = cyc;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      case (e.kind)
        KData:   act = dataR[e.port*DW +: DW];
        KPend:   act = {31'b0, rd_pend[e.port]};
        KBusy:   act = {31'b0, clr_busy};
        default: act = {31'b0, clr_done};
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d, queued %0d): got %h, want %h", e.name, cyc, e.cyc, act,
                 e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWEn    = 1'b0;
    alloc_en  = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    RegWEn = 1'b1;
    rsW    = AW'(a);
    dataW  = d;
  endtask

  task automatic rd(input int p, input int a);
    rsR[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    idle();
    rsW        = '0;
    dataW      = '0;
    rsR        = '0;
    alloc_addr = '0;

    // Reset held two cycles
    tick();
    tick();
    rd(0, 3);
    chk("rst_busy", KBusy, 0, 0);
    chk("rst_done", KDone, 0, 0);
    chk("rst_data", KData, 0, 0);
    chk("rst_pend", KPend, 0, 0);
    rst = 1'b1;

    // x0 is hardwired zero; normal write visible the next cycle
    tick();
    wr(0, 32'hBABABABA);
    rd(0, 0);
    chk("x0_pre", KData, 0, 0);
    tick();
    wr(3, 32'hBABABABA);
    rd(0, 0);
    rd(1, 3);
    chk("x0_discard", KData, 0, 0);
    chk("wr3_same", KData, 1, Byp ? 32'hBABABABA : 32'h0);
    tick();
    idle();
    chk("wr3_next", KData, 1, 32'hBABABABA);

    // Three read ports
    tick(); wr(4, 32'h11111111);
    tick(); wr(5, 32'h22222222);
    tick(); wr(6, 32'h33333333);
    tick();
    wr(4, 32'hFFFFFFFF);
    RegWEn = 1'b0;
    rd(0, 4); rd(1, 5); rd(2, 6);
    chk("mp_p0", KData, 0, 32'h11111111);
    chk("mp_p1", KData, 1, 32'h22222222);
    chk("mp_p2", KData, 2, 32'h33333333);
    tick();
    chk("wen0_keep", KData, 0, 32'h11111111);

    // Scoreboard
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    rd(0, 7);
    chk("alloc_same", KPend, 0, 0);
    tick();
    idle();
    chk("alloc_next", KPend, 0, 1);
    wr(7, 32'h77);
    chk("wb_same", KPend, 0, Byp ? 32'h0 : 32'h1);
    tick();
    idle();
    chk("wb_next", KPend, 0, 0);
    chk("wb_data", KData, 0, 32'h77);
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    wr(7, 32'h70);
    tick();
    idle();
    chk("set_wins", KPend, 0, 1);
    chk("set_wins_data", KData, 0, 32'h70);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    idle();
    rd(2, 0);
    chk("x0_nopend", KPend, 2, 0);

    // Forwarding
    tick();
    wr(8, 32'hCAFEF00D);
    rd(1, 8);
    chk("byp_same", KData, 1, Byp ? 32'hCAFEF00D : 32'h0);
    tick();
    idle();
    chk("byp_next", KData, 1, 32'hCAFEF00D);

    // Fill, then sweep
    for (int i = 1; i < 32; i++) begin
      tick();
      wr(i, 32'h10000000 + i);
    end
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd20;
    tick();
    idle();
    rd(0, 20);
    chk("fill_pend20", KPend, 0, 1);
    chk("fill_data20", KData, 0, 32'h10000014);
    clr_start = 1'b1;
    chk("sw_idle_busy", KBusy, 0, 0);
    for (int j = 0; j < 32; j++) begin
      tick();
      idle();
      clr_start = (j == 5);
      if (j == 9) wr(9, 32'hDEADBEEF);
      chk($sformatf("sw_busy_%0d", j), KBusy, 0, 1);
      chk($sformatf("sw_done_%0d", j), KDone, 0, (j == 31) ? 32'h1 : 32'h0);
    end
    tick();
    idle();
    chk("sw_end_busy", KBusy, 0, 0);
    chk("sw_end_done", KDone, 0, 0);
    for (int i = 0; i < 32; i++) begin
      rd(0, i);
      chk($sformatf("sw_data_%0d", i), KData, 0, (i == 9) ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("sw_pend_%0d", i), KPend, 0, 0);
      tick();
    end

    // Reset mid-sweep
    wr(25, 32'h25252525);
    tick();
    idle();
    rd(0, 25);
    chk("pre_rst_data", KData, 0, 32'h25252525);
    clr_start = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      tick();
      clr_start = 1'b0;
    end
    rst = 1'b0;
    rd(1, 9);
    chk("mid_rst_busy", KBusy, 0, 0);
    chk("mid_rst_done", KDone, 0, 0);
    chk("mid_rst_d25", KData, 0, 0);
    chk("mid_rst_d9", KData, 1, 0);
    tick();
    rst = 1'b1;
    chk("post_rst_busy", KBusy, 0, 0);
    tick();
    clr_start = 1'b1;
    for (int j = 0; j < 32; j++) begin
      tick();
      clr_start = 1'b0;
      chk($sformatf("rs_busy_%0d", j), KBusy, 0, 1);
      chk($sformatf("rs_done_%0d", j), KDone, 0, (j == 31) ? 32'h1 : 32'h0);
    end
    tick();
    chk("rs_end_busy", KBusy, 0, 0);

    tick();
    tick();
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
      errors += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
